change_dispenser: RTL and testbench

- Downstream of the vending state machine. Converts the change amount it produces into a sequence of physical coin/note eject pulses using greedy denominations 50/20/10/5/1.
- Exposes the remaining amount for the display block and reports busy/done back to the state machine.
- Runs in the single system clock domain.

---
 rtl/change_dispenser.sv | 96 +++++++++
 tb/tb_change_dispenser.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 50/20/10/5/1 eject sequencer with registered busy/done/remaining outputs.
// Define CHANGE_DISPENSER_COUNT_EN to add the eject_count output.
module change_dispenser #(
  parameter int AMOUNT_W     = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [AMOUNT_W-1:0] change_in,
  output logic                busy,
  output logic                done,
  output logic [AMOUNT_W-1:0] remaining,
  output logic                eject_fifty,
  output logic                eject_twenty,
  output logic                eject_ten,
  output logic                eject_five,
`ifdef CHANGE_DISPENSER_COUNT_EN
  output logic                eject_one,
  output logic [AMOUNT_W-1:0] eject_count
`else
  output logic                eject_one
`endif
);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0] den_q, den_d, den_sel, ej_q;
  logic [AMOUNT_W-1:0] rem_d, den_val;
  logic [31:0] rem32, dv;
  logic pulse_end;
  // one-hot denomination: bit 4 = 50 ... bit 0 = 1
  assign rem32 = 32'(remaining);
  assign den_sel = rem32 >= 32'd50 ? 5'b10000 : rem32 >= 32'd20 ? 5'b01000 :
                   rem32 >= 32'd10 ? 5'b00100 : rem32 >= 32'd5 ? 5'b00010 : 5'b00001;
  assign dv = den_q[4] ? 32'd50 : den_q[3] ? 32'd20 : den_q[2] ? 32'd10 : den_q[1] ? 32'd5 : 32'd1;
  assign den_val = dv[AMOUNT_W-1:0];
  assign pulse_end = state_q == PULSE && cnt_q == 16'(PULSE_CYCLES - 1);
  assign {eject_fifty, eject_twenty, eject_ten, eject_five, eject_one} = ej_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    den_d = den_q;
    rem_d = remaining;
    case (state_q)
      IDLE: if (start) begin
        state_d = SELECT;
        rem_d = change_in;
      end
      SELECT: begin
        cnt_d = '0;
        state_d = remaining == '0 ? DONE : PULSE;
        den_d = remaining == '0 ? den_q : den_sel;
      end
      PULSE: begin
        cnt_d = pulse_end ? '0 : cnt_q + 16'd1;
        state_d = pulse_end ? GAP : PULSE;
        rem_d = pulse_end ? remaining - den_val : remaining;
      end
      GAP: begin
        cnt_d = cnt_q == 16'(GAP_CYCLES - 1) ? '0 : cnt_q + 16'd1;
        state_d = cnt_q == 16'(GAP_CYCLES - 1) ? SELECT : GAP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from next-state so they align with the state they describe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      den_q <= '0;
      remaining <= '0;
      ej_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      den_q <= den_d;
      remaining <= rem_d;
      ej_q <= state_d == PULSE ? den_d : 5'b0;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
    end
  end
`ifdef CHANGE_DISPENSER_COUNT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) eject_count <= '0;
    else if (state_q == IDLE && start) eject_count <= '0;
    else if (pulse_end) eject_count <= eject_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed transactions with hand-computed eject sequences and timing.
module tb_change_dispenser;
  logic sys_clk = 0, sys_rst_n = 0, start = 0;
  logic [7:0] change_in = 0, remaining;
  logic busy, done, eject_fifty, eject_twenty, eject_ten, eject_five, eject_one;
`ifdef CHANGE_DISPENSER_COUNT_EN
  logic [7:0] eject_count;
`endif
  int n_tests = 0, n_fail = 0;
  int ej_seq[$], rem_seq[$];
  int done_cyc, done_cnt, bad_pw, bad_gap, oh_err, busy_err, busy_after, cnt_err;
  always #5 sys_clk = ~sys_clk;
  change_dispenser dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .change_in(change_in),
    .busy(busy), .done(done), .remaining(remaining),
    .eject_fifty(eject_fifty), .eject_twenty(eject_twenty), .eject_ten(eject_ten),
`ifdef CHANGE_DISPENSER_COUNT_EN
    .eject_five(eject_five), .eject_one(eject_one), .eject_count(eject_count)
`else
    .eject_five(eject_five), .eject_one(eject_one)
`endif
  );
  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic chk_q(input string tag, input int act[$], input int exp[$]);
    chk({tag, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), i < act.size() ? act[i] : -1, exp[i]);
  endtask
  // drives one transaction; inj>0 re-pulses start (amount 50) in that cycle
  task automatic run_txn(input int amt, input int inj);
    int prev_ej, ej, run, low_run, prev_rem, np;
    ej_seq.delete(); rem_seq.delete();
    done_cyc = -1; done_cnt = 0; bad_pw = 0; bad_gap = 0; oh_err = 0;
    busy_err = 0; busy_after = -1; cnt_err = 0;
    prev_ej = 0; run = 0; low_run = 0; np = 0;
    @(negedge sys_clk); change_in = 8'(amt); start = 1;
    @(posedge sys_clk);
    @(negedge sys_clk); start = 0;
    prev_rem = remaining; rem_seq.push_back(remaining);
    for (int c = 1; c < 2000; c++) begin
      ej = eject_fifty ? 50 : eject_twenty ? 20 : eject_ten ? 10 : eject_five ? 5 : eject_one ? 1 : 0;
      if ($countones({eject_fifty, eject_twenty, eject_ten, eject_five, eject_one}) > 1) oh_err++;
      if (ej != 0 && prev_ej == 0) begin
        ej_seq.push_back(ej);
        if (np > 0 && low_run != 5) bad_gap++;
        np++; run = 0;
      end
      if (ej != 0) run++;
      if (ej == 0 && prev_ej != 0) begin
        if (run != 4) bad_pw++;
        low_run = 0;
      end
      if (ej == 0) low_run++;
      if (ej != 0 && prev_ej != 0 && ej != prev_ej) bad_pw++;
`ifdef CHANGE_DISPENSER_COUNT_EN
      if (int'(eject_count) != (ej == 0 ? np : np - 1)) cnt_err++;
`endif
      if (int'(remaining) != prev_rem) rem_seq.push_back(remaining);
      prev_rem = remaining;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if ((done_cyc < 0 || c == done_cyc) && !busy) busy_err++;
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      start = (c == inj);
      if (c == inj) change_in = 8'd50;
      prev_ej = ej;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge sys_clk);
    end
    start = 0;
  endtask
  task automatic post(input string tag, input int exp_cyc);
    chk({tag, "_done_cyc"}, done_cyc, exp_cyc);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_pulse_w"}, bad_pw, 0);
    chk({tag, "_gap_w"}, bad_gap, 0);
    chk({tag, "_onehot"}, oh_err, 0);
    chk({tag, "_busy"}, busy_err, 0);
    chk({tag, "_busy_fall"}, busy_after, 0);
    chk({tag, "_rem_end"}, int'(remaining), 0);
`ifdef CHANGE_DISPENSER_COUNT_EN
    chk({tag, "_count_steps"}, cnt_err, 0);
    chk({tag, "_count_hold"}, int'(eject_count), ej_seq.size());
`endif
  endtask
  initial begin
    int bad;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_ej", int'({eject_fifty, eject_twenty, eject_ten, eject_five, eject_one}), 0);
    #20; @(negedge sys_clk); sys_rst_n = 1;
    run_txn(87, -1);
    post("t87", 56);
    chk_q("t87_ej", ej_seq, '{50, 20, 10, 5, 1, 1});
    chk_q("t87_rem", rem_seq, '{87, 37, 17, 7, 2, 1, 0});
    run_txn(0, -1);
    chk("t0_done_cyc", done_cyc, 2);
    chk("t0_done_cnt", done_cnt, 1);
    chk("t0_ej_cnt", ej_seq.size(), 0);
    chk("t0_busy", busy_err, 0);
    chk("t0_busy_fall", busy_after, 0);
`ifdef CHANGE_DISPENSER_COUNT_EN
    chk("t0_count_clr", int'(eject_count), 0);
`endif
    run_txn(255, -1);
    post("t255", 56);
    chk_q("t255_ej", ej_seq, '{50, 50, 50, 50, 50, 5});
    chk_q("t255_rem", rem_seq, '{255, 205, 155, 105, 55, 5, 0});
    run_txn(13, 12);
    post("t13", 38);
    chk_q("t13_ej", ej_seq, '{10, 1, 1, 1});
    chk_q("t13_rem", rem_seq, '{13, 3, 2, 1, 0});
    // asynchronous reset during the second pulse cycle of a 20 eject
    @(negedge sys_clk); change_in = 8'd20; start = 1;
    @(posedge sys_clk);
    @(negedge sys_clk); start = 0;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    chk("ar_pre_ej20", eject_twenty, 1);
    chk("ar_pre_rem", int'(remaining), 20);
    sys_rst_n = 0; #1;
    chk("ar_ej20", eject_twenty, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rem", int'(remaining), 0);
    @(negedge sys_clk); @(negedge sys_clk); sys_rst_n = 1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (done || busy || remaining != 0 || eject_twenty) bad++;
    end
    chk("ar_idle_after", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
